// File: rtl/vec_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : vec_frame_rx
// Description : Bit-serial frame receiver. Recovers the two 3-bit operands a
//               and b from a {~b, ~a} packed frame (start, 6 data bits LSB
//               first, even parity, stop), and presents a, b, a|b and |(a|b)
//               with a one-cycle valid pulse plus parity and framing flags.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_frame_rx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [2:0] out_or_bitwise,
    output logic       out_or_logical,
    output logic       out_valid,
    output logic       par_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = BIT_CYCLES / 2;
    localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_bit_m1  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       c_last_idx = 3'd5;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_parity    = 3'd3;
    localparam logic [2:0] c_st_stop      = 3'd4;
    localparam logic [2:0] c_st_wait_high = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [5:0]       r_data;
    logic             r_perr;
    logic [2:0]       r_a;
    logic [2:0]       r_b;
    logic [2:0]       r_or_bw;
    logic             r_or_lg;
    logic             r_valid;
    logic             r_par_err;
    logic             r_frame_err;

    logic [2:0]       w_a;
    logic [2:0]       w_b;
    logic             w_cnt_half;
    logic             w_cnt_bit;

    // Undo the transmit-side inversion and flag the sample points of the bit timer.
    always_comb begin
        w_a        = ~r_data[2:0];
        w_b        = ~r_data[5:3];
        w_cnt_half = (r_cnt == c_half_m1);
        w_cnt_bit  = (r_cnt == c_bit_m1);
    end

    // Receive state machine: bit timing, shift-in, parity/stop checks and output load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_perr      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_or_bw     <= '0;
            r_or_lg     <= 1'b0;
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Pulses and their qualifier default low every cycle.
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!rx) begin
                        r_state <= c_st_start;
                        r_cnt   <= '0;
                    end
                end
                c_st_start: begin
                    // Mid-bit recheck of the start bit rejects short glitches.
                    if (w_cnt_half) begin
                        if (rx) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_state <= c_st_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_cnt_bit) begin
                        r_cnt         <= '0;
                        r_data[r_idx] <= rx;
                        if (r_idx == c_last_idx) begin
                            r_state <= c_st_parity;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_parity: begin
                    if (w_cnt_bit) begin
                        r_cnt   <= '0;
                        r_perr  <= ^{r_data, rx};
                        r_state <= c_st_stop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    if (w_cnt_bit) begin
                        r_cnt <= '0;
                        if (rx) begin
                            // Good stop bit: present data even if parity failed.
                            r_a       <= w_a;
                            r_b       <= w_b;
                            r_or_bw   <= w_a | w_b;
                            r_or_lg   <= |(w_a | w_b);
                            r_valid   <= 1'b1;
                            r_par_err <= r_perr;
                            r_state   <= c_st_idle;
                        end else begin
                            // Broken frame: keep old outputs, wait for the line to recover.
                            r_frame_err <= 1'b1;
                            r_state     <= c_st_wait_high;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_wait_high: begin
                    if (rx) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Drive ports from their registers; busy is a direct decode of the state register.
    always_comb begin
        a              = r_a;
        b              = r_b;
        out_or_bitwise = r_or_bw;
        out_or_logical = r_or_lg;
        out_valid      = r_valid;
        par_err        = r_par_err;
        frame_err      = r_frame_err;
        busy           = (r_state != c_st_idle);
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_frame_rx
// Description : Self-checking bench for vec_frame_rx. Table of directed frames
//               with hand-computed decode results, plus hand-written sequences
//               for framing error, false start, back-to-back frames and reset
//               in the middle of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_frame_rx;

    localparam int BC = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] out_or_bitwise;
    logic       out_or_logical;
    logic       out_valid;
    logic       par_err;
    logic       frame_err;
    logic       busy;

    vec_frame_rx #(.BIT_CYCLES(BC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx),
        .a              (a),
        .b              (b),
        .out_or_bitwise (out_or_bitwise),
        .out_or_logical (out_or_logical),
        .out_valid      (out_valid),
        .par_err        (par_err),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cycle counter and pulse monitor (only this block writes these).
    int cyc      = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_qual   = 0;
    int v_cyc    = 0;
    int v_cyc_pr = 0;
    logic cap_pe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each pulse and any flag raised without its qualifying pulse.
    always @(negedge clk) begin
        if (out_valid) begin
            n_valid  <= n_valid + 1;
            v_cyc_pr <= v_cyc;
            v_cyc    <= cyc;
            cap_pe   <= par_err;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if ((par_err && !out_valid) || (frame_err && out_valid)) n_qual <= n_qual + 1;
    end

    typedef struct {
        logic [5:0] data;
        logic       par;
        logic [2:0] ea;
        logic [2:0] eb;
        logic [2:0] ebw;
        logic       elg;
        logic       epe;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one full 9-bit frame; called right after a falling edge.
    task automatic send_frame(input logic [5:0] data, input logic par, input logic stp,
                              output int e0);
        rx = 1'b0;
        e0 = cyc + 1;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rx = data[i];
            repeat (BC) @(negedge clk);
        end
        rx = par;
        repeat (BC) @(negedge clk);
        rx = stp;
        repeat (BC) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int e0;
    int e0b;
    int nv0;
    int nf0;
    int bad;

    initial begin
        //                data       par   a       b       a|b     |   pe
        vecs[0] = '{6'b101010, 1'b1, 3'b101, 3'b010, 3'b111, 1'b1, 1'b0};
        vecs[1] = '{6'b111111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[2] = '{6'b101010, 1'b0, 3'b101, 3'b010, 3'b111, 1'b1, 1'b1};
        vecs[3] = '{6'b011110, 1'b0, 3'b001, 3'b100, 3'b101, 1'b1, 1'b0};
        vecs[4] = '{6'b100111, 1'b0, 3'b000, 3'b011, 3'b011, 1'b1, 1'b0};
        vecs[5] = '{6'b000000, 1'b0, 3'b111, 3'b111, 3'b111, 1'b1, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a_b",   int'({a, b}), 0);
        chk("reset_or",    int'({out_or_bitwise, out_or_logical}), 0);
        chk("reset_flags", int'({out_valid, par_err, frame_err, busy}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table of frames.
        for (int k = 0; k < 6; k++) begin
            nv0 = n_valid;
            send_frame(vecs[k].data, vecs[k].par, 1'b1, e0);
            idle(4);
            chk($sformatf("v%0d_valid_cnt", k), n_valid - nv0, 1);
            chk($sformatf("v%0d_latency", k), v_cyc - e0, 34);
            chk($sformatf("v%0d_a", k), int'(a), int'(vecs[k].ea));
            chk($sformatf("v%0d_b", k), int'(b), int'(vecs[k].eb));
            chk($sformatf("v%0d_or_bw", k), int'(out_or_bitwise), int'(vecs[k].ebw));
            chk($sformatf("v%0d_or_lg", k), int'(out_or_logical), int'(vecs[k].elg));
            chk($sformatf("v%0d_par_err", k), int'(cap_pe), int'(vecs[k].epe));
            chk($sformatf("v%0d_busy_idle", k), int'(busy), 0);
        end

        // Framing error: stop=0, line held low 20 cycles, then 1 high cycle.
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(6'b001100, 1'b0, 1'b0, e0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) bad++;
            @(negedge clk);
        end
        chk("ferr_busy_wait_high", bad, 0);
        chk("ferr_pulse_cnt", n_ferr - nf0, 1);
        chk("ferr_no_valid", n_valid - nv0, 0);
        chk("ferr_a_kept", int'(a), 3'b111);
        chk("ferr_b_kept", int'(b), 3'b111);
        rx = 1'b1;
        @(negedge clk);
        chk("ferr_back_idle", int'(busy), 0);
        nv0 = n_valid;
        send_frame(vecs[0].data, vecs[0].par, 1'b1, e0);
        idle(4);
        chk("ferr_recover_valid", n_valid - nv0, 1);
        chk("ferr_recover_ab", int'({a, b}), int'({3'b101, 3'b010}));

        // False start glitch, then two frames with no idle gap.
        nv0 = n_valid;
        rx = 1'b0;
        @(negedge clk);
        idle(4);
        chk("glitch_busy", int'(busy), 0);
        chk("glitch_no_valid", n_valid - nv0, 0);
        send_frame(vecs[3].data, vecs[3].par, 1'b1, e0);
        send_frame(vecs[4].data, vecs[4].par, 1'b1, e0b);
        idle(4);
        chk("b2b_valid_cnt", n_valid - nv0, 2);
        chk("b2b_gap", v_cyc - v_cyc_pr, 36);
        chk("b2b_latency2", v_cyc - e0b, 34);
        chk("b2b_ab", int'({a, b}), int'({3'b000, 3'b011}));

        // Reset asserted during data bit 3.
        nv0 = n_valid;
        rx = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = vecs[0].data[i];
            repeat (BC) @(negedge clk);
        end
        rx = vecs[0].data[3];
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ab", int'({a, b}), 0);
        chk("rst_async_or", int'({out_or_bitwise, out_or_logical}), 0);
        chk("rst_async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(40);
        chk("rst_no_partial", n_valid - nv0, 0);
        send_frame(vecs[3].data, vecs[3].par, 1'b1, e0);
        idle(4);
        chk("rst_after_valid", n_valid - nv0, 1);
        chk("rst_after_latency", v_cyc - e0, 34);
        chk("rst_after_ab", int'({a, b}), int'({3'b001, 3'b100}));
        chk("rst_after_or", int'({out_or_bitwise, out_or_logical}), int'({3'b101, 1'b1}));

        chk("flag_qualification", n_qual, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_frame_rx.md
# vec_frame_rx

Serial receiver that reconstructs the pair of 3-bit operand vectors from a bit-serial frame and presents them in parallel, along with their bitwise and logical OR. The transmit side packs each frame as a 6-bit word, {~b, ~a}, with the inverted b in bits [5:3] and the inverted a in bits [2:0]. This block undoes that packing, checks parity and framing, and hands a, b and the OR results to downstream logic as a one-cycle valid pulse.

## Interface
- BIT_CYCLES, 4: clock cycles per serial bit; legal range 2..255; HALF = BIT_CYCLES/2 (integer division).
- clk  input  1  single clock; everything is rising-edge.
- rst_n  input  1  asynchronous, active-low reset. Releasing it is synchronised by the system.
- rx  input  1  serial line; idles high; already synchronous to clk.
- a  output  3  decoded a = ~data[2:0]; registered.
- b  output  3  decoded b = ~data[5:3]; registered.
- out_or_bitwise  output  3  a | b; registered together with a and b.
- out_or_logical  output  1  1 when (a|b) != 0; registered.
- out_valid  output  1  one-cycle pulse: a, b and the OR outputs are new.
- par_err  output  1  qualifies out_valid: even parity failed.
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
- busy  output  1  high in every state except IDLE.

## Operation
- Frame format:
  - start bit (0);
  - 6 data bits, LSB first (data[0] first);
  - parity bit, even over data plus parity;
  - stop bit (1).
- Bit counter: width sufficient for BIT_CYCLES-1.
- States and transitions:
  - IDLE: when rx==0 at an edge, go to START with cnt=0.
  - START: when cnt==HALF-1, sample rx.
    - rx==1 is a false start: go to IDLE with no output.
    - rx==0: cnt=0, bit index=0, go to DATA.
  - DATA: each time cnt==BIT_CYCLES-1, sample rx into data[idx] and restart cnt. After idx 5, go to PARITY.
  - PARITY: sample at cnt==BIT_CYCLES-1 and compute err = ^{data, rx}. Go to STOP.
  - STOP: sample at cnt==BIT_CYCLES-1.
    - rx==1: load a, b, out_or_bitwise, out_or_logical; pulse out_valid; drive par_err=err; go to IDLE.
    - rx==0: pulse frame_err; a and b keep their old values; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx==1 at an edge, then go to IDLE. A low line never starts a frame from this state.
- Reset values: a=0, b=0, out_or_bitwise=0, out_or_logical=0, out_valid=0, par_err=0, frame_err=0, busy=0; state=IDLE; cnt, index and shift register all 0.
- par_err and frame_err are 0 in every cycle where their qualifying pulse is 0.
- A parity error does not suppress data: out_valid still pulses and the data is presented.
- rx is ignored in all states between sample points.

## Timing
- Let E0 be the edge at which IDLE sees rx==0. Sample edges are:
  - start bit: E0+HALF;
  - data[i]: E0+HALF+(i+1)·BIT_CYCLES;
  - parity: E0+HALF+7·BIT_CYCLES;
  - stop: E0+HALF+8·BIT_CYCLES.
- Outputs update at the stop sample edge and are visible in the cycle that follows. out_valid and frame_err are high for exactly one cycle.
- Back-to-back frames: IDLE is entered at the stop edge, so a start bit can be detected at the very next edge. Zero idle bits between frames is legal.
- Reset mid-frame: all outputs go to their reset values immediately, without waiting for a clock. No partial frame is ever emitted. After release, the first rx==0 in IDLE begins a fresh frame.
- With BIT_CYCLES=2, HALF=1: the start bit is sampled one edge after detection.

## Test plan
- Basic decode, BIT_CYCLES=4:
  - Stimulus: a=101, b=010, so data=101010 and the serial bits are 0,1,0,1,0,1, parity=1, stop=1.
  - Required: out_valid pulses at E0+34; a=101, b=010, out_or_bitwise=111, out_or_logical=1, par_err=0.
- All-zero operands:
  - Stimulus: data=111111, parity=0.
  - Required: a=000, b=000, out_or_bitwise=000, out_or_logical=0, out_valid=1.
- Bad parity:
  - Stimulus: the first frame with parity=0.
  - Required: out_valid=1 with par_err=1, a=101, b=010.
- Framing error:
  - Stimulus: stop=0, then rx held low for 20 cycles, then high for 1 cycle, then a good frame.
  - Required:
    - frame_err pulses once, out_valid=0, a and b unchanged;
    - busy stays 1 through WAIT_HIGH;
    - the good frame then decodes correctly.
- False start and back-to-back frames:
  - Stimulus: a 1-cycle low glitch on rx, then two frames with no idle gap.
  - Required: the glitch produces no output and busy drops back to 0. The two frames produce two out_valid pulses exactly 36 cycles apart.
- Reset mid-frame:
  - Stimulus: rst_n=0 during data bit 3 of a frame.
  - Required: all outputs are 0 asynchronously and no out_valid is produced. After release, the next full frame decodes normally.
